// File: rtl/cpu_pkg.sv
// Shared definitions for the core's run-control logic: state encoding and
// default fetch parameters.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam int          DEFAULT_ADDR_W    = 5;
  localparam int          DEFAULT_RESET_PC  = 0;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/retire_counter.sv
// Saturating retired-instruction counter with synchronous clear and a
// terminal-count flag that fires one retirement before MAX_COUNT.
module retire_counter #(
  parameter int CNT_W     = 16,
  parameter int MAX_COUNT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MAX_COUNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the terminal-count compare entirely.
  assign tc_o    = (MAX_COUNT != 0) && (cnt_q == TC_VAL);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control and fetch sequencer: owns the PC, gates instruction commit,
// detects the halt word and enforces an optional retirement watchdog.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [31:0]       HALT_WORD  = DEFAULT_HALT_WORD,
  parameter int                CNT_W      = 16,
  parameter int                MAX_RETIRE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic [31:0]       instr,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              commit,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  retired,
  output logic [1:0]        state
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              timeout_q, timeout_d;
  logic              cntClr;
  logic              wdTc;
  logic              isHalt;
  logic              wdFire;

  assign isHalt = (instr == HALT_WORD);
  assign commit = ((state_q == RUN) || (state_q == STEP)) && !isHalt;
  assign wdFire = commit && wdTc;

  retire_counter #(
    .CNT_W    (CNT_W),
    .MAX_COUNT(MAX_RETIRE)
  ) u_retire_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cntClr),
    .inc_i  (commit),
    .count_o(retired),
    .tc_o   (wdTc)
  );

  // Halt word outranks the watchdog, which outranks stop / step completion.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    timeout_d = timeout_q;
    cntClr    = 1'b0;

    if (commit) begin
      pc_d = branch_taken ? branch_target : pc_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else if (step) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (isHalt) begin
          state_d = HALTED;
        end else if (wdFire) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end else if (stop) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (isHalt) begin
          state_d = HALTED;
        end else if (wdFire) begin
          state_d   = HALTED;
          timeout_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HALTED: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = RESET_PC;
          timeout_d = 1'b0;
          cntClr    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      timeout_q <= timeout_d;
    end
  end

  assign pc      = pc_q;
  assign halted  = (state_q == HALTED);
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: one instance with the watchdog off
// and one with a limit of four retirements, sharing clock, reset and controls.
module tb_fetch_sequencer;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        stop = 1'b0;

  logic [31:0] rom [32];
  logic        brEn [32];
  logic [4:0]  brTgt [32];

  logic [31:0] instr;
  logic        branch_taken;
  logic [4:0]  branch_target;
  logic [4:0]  pc;
  logic        commit, halted, timeout;
  logic [15:0] retired;
  logic [1:0]  state;

  logic [31:0] wdInstr = NOP;
  logic        wdBrTaken = 1'b0;
  logic [4:0]  wdBrTgt = 5'd0;
  logic [4:0]  wdPc;
  logic        wdCommit, wdHalted, wdTimeout;
  logic [15:0] wdRetired;
  logic [1:0]  wdState;

  logic [31:0] mainQ [$];
  logic [31:0] wdQ [$];
  logic        mainMon = 1'b0;
  logic        wdMon = 1'b0;
  logic [31:0] mainExp, wdExp;

  int compared = 0;
  int mismatched = 0;

  assign instr         = rom[pc];
  assign branch_taken  = brEn[pc];
  assign branch_target = brTgt[pc];

  always #5 clk = ~clk;

  fetch_sequencer #(.MAX_RETIRE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
    .instr(instr), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .commit(commit), .halted(halted), .timeout(timeout),
    .retired(retired), .state(state)
  );

  fetch_sequencer #(.MAX_RETIRE(4)) dutWd (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
    .instr(wdInstr), .branch_taken(wdBrTaken), .branch_target(wdBrTgt),
    .pc(wdPc), .commit(wdCommit), .halted(wdHalted), .timeout(wdTimeout),
    .retired(wdRetired), .state(wdState)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic sp);
    start = s;
    step  = st;
    stop  = sp;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadNops();
    for (int i = 0; i < 32; i++) begin
      rom[i]   = NOP;
      brEn[i]  = 1'b0;
      brTgt[i] = 5'd0;
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitPc(input logic [4:0] target);
    @(negedge clk);
    for (int i = 0; i < 40 && pc != target; i++) @(negedge clk);
    checkOutput("reachPc", 32'(pc), 32'(target));
  endtask

  // Each commit seen at a falling edge retires at the next rising edge.
  always @(negedge clk) begin
    if (mainMon && commit) begin
      if (mainQ.size() == 0) begin
        checkOutput("mainExtraCommit", 32'(commit), 32'd0);
      end else begin
        mainExp = mainQ.pop_front();
        checkOutput("mainCommitPc", 32'(pc), mainExp);
      end
    end
    if (wdMon && wdCommit) begin
      if (wdQ.size() == 0) begin
        checkOutput("wdExtraCommit", 32'(wdCommit), 32'd0);
      end else begin
        wdExp = wdQ.pop_front();
        checkOutput("wdCommitPc", 32'(wdPc), wdExp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    loadNops();

    // Reset values
    doReset();
    checkOutput("rstPc", 32'(pc), 32'd0);
    checkOutput("rstState", 32'(state), 32'd0);
    checkOutput("rstRetired", 32'(retired), 32'd0);
    checkOutput("rstTimeout", 32'(timeout), 32'd0);
    checkOutput("rstHalted", 32'(halted), 32'd0);
    checkOutput("rstCommit", 32'(commit), 32'd0);

    // Program with a taken branch and halt words
    rom[0] = 32'h00F0_0093;
    rom[1] = 32'h00F0_0113;
    rom[2] = 32'h0020_8663;
    rom[3] = 32'h0010_2023;
    rom[4] = HALT;
    rom[5] = 32'h0450_0093;
    rom[6] = 32'h0010_2023;
    rom[7] = HALT;
    brEn[2] = 1'b1;
    brTgt[2] = 5'd5;
    mainQ = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd6};
    mainMon = 1'b1;
    pulseStart();
    @(negedge clk);
    for (int i = 0; i < 30 && !halted; i++) @(negedge clk);
    checkOutput("progHalted", 32'(halted), 32'd1);
    checkOutput("progPc", 32'(pc), 32'd7);
    checkOutput("progRetired", 32'(retired), 32'd5);
    checkOutput("progTimeout", 32'(timeout), 32'd0);
    checkOutput("progCommit", 32'(commit), 32'd0);
    checkOutput("progQEmpty", 32'(mainQ.size()), 32'd0);

    // Single-step three times
    loadNops();
    doReset();
    mainQ = '{32'd0, 32'd1, 32'd2};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 applyStimulus(1'b0, 1'b1, 1'b0);
      @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("stepState", 32'(state), 32'd2);
      @(negedge clk);
      checkOutput("stepIdle", 32'(state), 32'd0);
    end
    checkOutput("stepPc", 32'(pc), 32'd3);
    checkOutput("stepRetired", 32'(retired), 32'd3);
    checkOutput("stepQEmpty", 32'(mainQ.size()), 32'd0);

    // Stop while pc=1, then resume
    doReset();
    mainQ = '{32'd0, 32'd1};
    pulseStart();
    waitPc(5'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stopState", 32'(state), 32'd0);
    checkOutput("stopPc", 32'(pc), 32'd2);
    mainQ.push_back(32'd2);
    mainQ.push_back(32'd3);
    pulseStart();
    waitPc(5'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("resumeState", 32'(state), 32'd0);
    checkOutput("resumePc", 32'(pc), 32'd4);
    checkOutput("resumeRetired", 32'(retired), 32'd4);
    checkOutput("resumeQEmpty", 32'(mainQ.size()), 32'd0);

    // Watchdog with a limit of four retirements
    mainMon = 1'b0;
    doReset();
    wdQ = '{32'd0, 32'd1, 32'd2, 32'd3};
    wdMon = 1'b1;
    pulseStart();
    @(negedge clk);
    for (int i = 0; i < 30 && !wdHalted; i++) @(negedge clk);
    checkOutput("wdHalted", 32'(wdHalted), 32'd1);
    checkOutput("wdTimeout", 32'(wdTimeout), 32'd1);
    checkOutput("wdRetired", 32'(wdRetired), 32'd4);
    checkOutput("wdPc", 32'(wdPc), 32'd4);
    checkOutput("wdQEmpty", 32'(wdQ.size()), 32'd0);
    wdMon = 1'b0;
    pulseStart();
    @(negedge clk);
    checkOutput("wdRestartState", 32'(wdState), 32'd1);
    checkOutput("wdRestartPc", 32'(wdPc), 32'd0);
    checkOutput("wdRestartRetired", 32'(wdRetired), 32'd0);
    checkOutput("wdRestartTimeout", 32'(wdTimeout), 32'd0);

    // Free run with start held high: pc wraps 31 -> 0
    doReset();
    for (int i = 0; i < 40; i++) mainQ.push_back(32'(i % 32));
    mainMon = 1'b1;
    @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    repeat (40) @(posedge clk);
    #1 mainMon = 1'b0;
    @(negedge clk);
    checkOutput("wrapPc", 32'(pc), 32'd8);
    checkOutput("wrapRetired", 32'(retired), 32'd40);
    checkOutput("wrapState", 32'(state), 32'd1);
    checkOutput("wrapQEmpty", 32'(mainQ.size()), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Asynchronous reset between clock edges mid-run
    doReset();
    pulseStart();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("asyncPc", 32'(pc), 32'd0);
    checkOutput("asyncState", 32'(state), 32'd0);
    checkOutput("asyncCommit", 32'(commit), 32'd0);
    checkOutput("asyncRetired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
